// File: rtl/vector_extension_writeback.sv
// Vector extension writeback: buffers a widened 512-bit result and
// serialises it into per-register VRF writes over the destination group.
module vector_extension_writeback #(
  parameter int VLEN      = 64,
  parameter int NUM_VREGS = 32,
  parameter int MAX_GROUP = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    ext_factor,
  input  logic [$clog2(NUM_VREGS)-1:0]  vd_address,
  input  logic [VLEN-1:0]               vd,
  input  logic [VLEN-1:0]               vd_high,
  input  logic [VLEN*(MAX_GROUP-2)-1:0] vd_extra,
  output logic                          vrf_write_enable,
  output logic [$clog2(NUM_VREGS)-1:0]  vrf_write_address,
  output logic [VLEN-1:0]               vrf_write_data,
  input  logic                          vrf_write_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal
);

  localparam int AW = $clog2(NUM_VREGS);
  localparam int IW = $clog2(MAX_GROUP);
  localparam int BW = VLEN * MAX_GROUP;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE,
    FAULT
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   buf_q;
  logic [AW-1:0]   base_q;
  logic [IW:0]     cnt_q;
  logic [IW-1:0]   idx_q;
  logic            in_ready_q;
  logic            wen_q;
  logic [AW-1:0]   waddr_q;
  logic [VLEN-1:0] wdata_q;
  logic            busy_q;
  logic            done_q;
  logic            illegal_q;

  logic [IW:0]     cnt_d;
  logic [IW-1:0]   idx_d;
  logic            accept;
  logic            bad_req;
  logic            last_beat;

  always_comb begin
    cnt_d     = (IW+1)'(1) << ext_factor;
    idx_d     = idx_q + IW'(1);
    accept    = in_valid && in_ready_q;
    // A group of 2^k registers must start on a 2^k boundary
    bad_req   = (ext_factor == 2'b00) ||
                ((vd_address & AW'(cnt_d - (IW+1)'(1))) != '0);
    last_beat = ({1'b0, idx_q} == (cnt_q - (IW+1)'(1)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buf_q      <= {vd_extra, vd_high, vd};
            base_q     <= vd_address;
            cnt_q      <= cnt_d;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bad_req) begin
              state_q   <= FAULT;
              illegal_q <= 1'b1;
            end else begin
              state_q <= WRITE;
              wen_q   <= 1'b1;
              waddr_q <= vd_address;
              wdata_q <= vd;
            end
          end
        end
        WRITE: begin
          if (vrf_write_ready) begin
            if (last_beat) begin
              state_q <= DONE;
              wen_q   <= 1'b0;
              waddr_q <= '0;
              wdata_q <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              waddr_q <= base_q + AW'(idx_d);
              wdata_q <= buf_q[idx_d*VLEN +: VLEN];
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        FAULT: begin
          state_q    <= IDLE;
          illegal_q  <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign vrf_write_enable  = wen_q;
  assign vrf_write_address = waddr_q;
  assign vrf_write_data    = wdata_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign illegal           = illegal_q;

endmodule

// File: doc/vector_extension_writeback.md
Name: vector_extension_writeback

Overview:
- Downstream of vector_extension_unit.
- Captures the widened 512-bit extension result (vd, vd_high, vd_extra) in one handshake.
- Serialises it into 64-bit writes to the vector register file across the destination register group: 2, 4 or 8 registers for vf2/vf4/vf8.
- Applies VRF backpressure, checks group alignment, and signals completion to the issue logic.

Parameters:
- VLEN, 64, register width in bits; equals one write beat.
- NUM_VREGS, 32, number of architectural vector registers; the address width is log2(NUM_VREGS) = 5.
- MAX_GROUP, 8, maximum number of destination registers per instruction; the buffer is VLEN*MAX_GROUP = 512 bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  block can accept a result.
- ext_factor  in  2  01=vf2, 10=vf4, 11=vf8, 00=illegal.
- vd_address  in  5  base destination register.
- vd  in  64  result bits [63:0].
- vd_high  in  64  result bits [127:64].
- vd_extra  in  384  result bits [511:128].
- vrf_write_enable  out  1  write request to the VRF.
- vrf_write_address  out  5  destination register of the current beat.
- vrf_write_data  out  64  data of the current beat.
- vrf_write_ready  in  1  VRF accepts the beat this cycle.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse after the last beat is accepted.
- illegal  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: in_ready=0 while reset is asserted and 1 in the first cycle after release. All other outputs 0, state=IDLE, beat counter=0, buffer=0.
- FSM states: IDLE, WRITE, DONE, FAULT.

IDLE:
- in_ready=1.
- Accept when in_valid && in_ready.
  - Latch {vd_extra, vd_high, vd} into the buffer, the base address and beat_count = 2^ext_factor (2/4/8).
  - If ext_factor=00, or vd_address is not a multiple of beat_count, go to FAULT. For 00 the alignment check is skipped.
  - Otherwise go to WRITE with beat index i=0.

WRITE:
- Outputs: vrf_write_enable=1, vrf_write_address=base+i, vrf_write_data=buffer[64*i +: 64].
- The beat is accepted in any cycle where vrf_write_ready=1.
  - On acceptance, i increments.
  - If i was beat_count-1, go to DONE.
- If vrf_write_ready=0, hold address, data and enable stable, with no other change.
- Writes never wrap past register 31: alignment guarantees base+beat_count-1 <= 31.

DONE:
- done=1 for exactly one cycle, vrf_write_enable=0, then IDLE.

FAULT:
- illegal=1 for exactly one cycle, with no VRF writes and done=0, then IDLE.

Timing and latency:
- Accept at cycle N. With vrf_write_ready held high, beats occur in cycles N+1 .. N+beat_count, done in N+beat_count+1, and in_ready returns in N+beat_count+2.
- in_ready=0 from the cycle after acceptance until the return to IDLE. There is no overlap between requests.

Handshake and corner cases:
- in_valid while busy is ignored. Upstream must hold the request until in_ready.
- Input changes after acceptance do not affect the buffered data.
- Reset asserted mid-WRITE: all outputs drop to 0 immediately (asynchronously), the remaining beats are discarded, and no done is issued.
- The upper buffer segments are written as captured. The upstream stage supplies zeros for unused lanes; this block does not mask them.

Test Plan:
1. vf2, vd_address=4, vd=64'h1111_2222_3333_4444, vd_high=64'hAAAA_BBBB_CCCC_DDDD, vrf_write_ready=1 -> writes reg4=1111_2222_3333_4444 and reg5=AAAA_BBBB_CCCC_DDDD in consecutive cycles, done one cycle later, in_ready one cycle after that.
2. vf8, vd_address=8, buffer lanes k=0..7 set to 64'h0…0k -> eight consecutive writes, reg8+k=k; done at N+9.
3. vf4, vd_address=12, vrf_write_ready low for 3 cycles during beat 1 -> reg13 address and data held stable for 3 cycles, order reg12..reg15 preserved, done one cycle after the reg15 write.
4. vf4, vd_address=6 (misaligned); then ext_factor=00, vd_address=0 -> each gives illegal pulse at N+1, no vrf_write_enable, done=0, in_ready back at N+2.
5. vf8, vd_address=16, reset asserted after 3 beats (reg16..reg18 written) -> outputs 0 immediately, no reg19 write, no done; a fresh vf2 request after reset completes normally.
6. in_valid asserted with new data while busy during a vf4 write -> second request ignored until in_ready=1, then accepted with its own data.
